// File: rtl/board_status_display_pkg.sv
// board_display_pkg: display modes, active-low gfedcba segment glyphs and the hex glyph decoder
package board_display_pkg;

    typedef enum logic [1:0] {STATUS, VALUE, LOCK_ALERT} mode_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_HB    = 7'b0100011;
    localparam logic [6:0] SEG_R     = 7'b1010111;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_P     = 7'b0001100;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

endpackage

// File: rtl/board_status_display_if.sv
// board_status_display_if: value bus from the SoC into the board display
interface board_status_display_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic [4*NUM_DIGITS-1:0] value;
    logic                    value_valid;

    modport master (output value, output value_valid);
    modport slave  (input value, input value_valid);
endinterface

// File: rtl/board_status_display_debounce.sv
// button_debounce: synchronises one raw active-low key and accepts a new level only after it has held long enough
module button_debounce #(
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic CLOCK_50,
    input  logic HRESETn,
    input  logic key_n,
    output logic stable,
    output logic press
);

    logic [1:0]               sync;
    logic [DEBOUNCE_BITS-1:0] cnt;

    // count cycles of disagreement; flip the accepted level once the counter has saturated
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            sync   <= '0;
            cnt    <= '0;
            stable <= 1'b0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], ~key_n};
            press <= 1'b0;
            if (sync[1] == stable) cnt <= '0;
            else if (&cnt) begin
                cnt    <= '0;
                stable <= ~stable;
                press  <= ~stable;
            end else cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/board_status_display.sv
// board_status_display: heartbeat/running indicators, key debouncing and mode-driven seven-segment display
module board_status_display
    import board_display_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int NUM_BUTTONS   = 2,
    parameter int HB_MSB        = 25,
    parameter int DEBOUNCE_BITS = 16
) (
    input  logic                     CLOCK_50,
    input  logic                     HRESETn,
    input  logic                     LOCKUP,
    board_status_display_if.slave    bus,
    input  logic [NUM_BUTTONS-1:0]   KEY_n,
    output logic [NUM_BUTTONS-1:0]   buttons,
    output logic [NUM_BUTTONS-1:0]   button_press,
    output logic                     running,
    output logic                     heartbeat,
    output mode_t                    mode,
    output logic [7*NUM_DIGITS-1:0]  HEX
);

    logic [HB_MSB:0]         tick;
    logic [4*NUM_DIGITS-1:0] value_reg;
    logic [7*NUM_DIGITS-1:0] hex_next;

    for (genvar b = 0; b < NUM_BUTTONS; b++) begin : g_btn
        button_debounce #(.DEBOUNCE_BITS(DEBOUNCE_BITS)) u_db (
            .CLOCK_50 (CLOCK_50),
            .HRESETn  (HRESETn),
            .key_n    (KEY_n[b]),
            .stable   (buttons[b]),
            .press    (button_press[b])
        );
    end

    // free-running tick, heartbeat decoded from it one cycle late, running set from the first clock
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) begin
            tick      <= '0;
            heartbeat <= 1'b0;
            running   <= 1'b0;
        end else begin
            tick      <= tick + 1'b1;
            heartbeat <= tick[HB_MSB] & tick[HB_MSB-2];
            running   <= 1'b1;
        end
    end

    // mode FSM: lockup overrides everything, button 0 cycles STATUS/VALUE and acknowledges an alert
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) mode <= STATUS;
        else if (LOCKUP) mode <= LOCK_ALERT;
        else begin
            case (mode)
                STATUS:     mode <= button_press[0] ? VALUE : STATUS;
                VALUE:      mode <= button_press[0] ? STATUS : VALUE;
                LOCK_ALERT: mode <= button_press[0] ? STATUS : LOCK_ALERT;
                default:    mode <= STATUS;
            endcase
        end
    end

    // capture the displayed value whenever the SoC offers one, regardless of mode
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) value_reg <= '0;
        else if (bus.value_valid) value_reg <= bus.value;
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
        if (d < 4) begin : g_low
            logic [6:0] st, lk;
            assign lk = d == 3 ? SEG_L : d == 2 ? SEG_O : d == 1 ? SEG_C : SEG_P;
            assign st = d == 0 ? (heartbeat ? SEG_HB : SEG_BLANK) :
                        d == 1 ? (!LOCKUP ? SEG_DASH : SEG_BLANK) :
                        d == 2 ? (running ? SEG_R : SEG_BLANK) :
                                 (LOCKUP ? SEG_L : SEG_BLANK);
            assign hex_next[7*d +: 7] = mode == VALUE      ? hex_to_seg(value_reg[4*d +: 4]) :
                                        mode == LOCK_ALERT ? (heartbeat ? lk : SEG_BLANK) :
                                        mode == STATUS     ? st : SEG_BLANK;
        end else begin : g_high
            assign hex_next[7*d +: 7] = mode == VALUE ? hex_to_seg(value_reg[4*d +: 4]) : SEG_BLANK;
        end
    end

    // register the segment pattern so the pins never see decode glitches
    always_ff @(posedge CLOCK_50 or negedge HRESETn) begin
        if (!HRESETn) HEX <= '1;
        else HEX <= hex_next;
    end

endmodule

// File: tb/tb_board_status_display.sv
// tb_board_status_display: randomized and directed checks of the board display against a cycle reference model
module tb_board_status_display;

    localparam int ND = 4;
    localparam int NB = 2;
    localparam logic [6:0] BL = 7'h7F, HBG = 7'h23, RG = 7'h57, LG = 7'h47, DG = 7'h3F;
    localparam logic [6:0] OG = 7'h40, CG = 7'h46, PG = 7'h0C;

    logic CLOCK_50 = 1'b0;
    logic HRESETn = 1'b1;
    logic LOCKUP = 1'b0;
    logic [NB-1:0] KEY_n = '1;
    logic [NB-1:0] buttons, button_press;
    logic running, heartbeat;
    logic [1:0] mode;
    logic [7*ND-1:0] HEX;

    board_status_display_if #(.NUM_DIGITS(ND)) bus ();

    board_status_display #(.NUM_DIGITS(ND), .NUM_BUTTONS(NB), .HB_MSB(4), .DEBOUNCE_BITS(3)) dut (
        .CLOCK_50     (CLOCK_50),
        .HRESETn      (HRESETn),
        .LOCKUP       (LOCKUP),
        .bus          (bus),
        .KEY_n        (KEY_n),
        .buttons      (buttons),
        .button_press (button_press),
        .running      (running),
        .heartbeat    (heartbeat),
        .mode         (mode),
        .HEX          (HEX)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int n_checks = 0;
    int n_pass = 0;

    int m_tick, m_mode;
    bit m_hb, m_run;
    logic [15:0] m_val;
    logic [27:0] m_hex;
    bit [NB-1:0] s1, s2, stb, prs;
    int runlen [NB];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [27:0] disp();
        logic [27:0] h;
        h = '1;
        if (m_mode == 1) for (int d = 0; d < 4; d++) h[7*d +: 7] = glyph[m_val[4*d +: 4]];
        else if (m_mode == 2) h = m_hb ? {LG, OG, CG, PG} : '1;
        else h = {LOCKUP ? LG : BL, m_run ? RG : BL, !LOCKUP ? DG : BL, m_hb ? HBG : BL};
        return h;
    endfunction

    task automatic model_reset();
        m_tick = 0; m_mode = 0; m_hb = 0; m_run = 0; m_val = '0; m_hex = '1;
        s1 = '0; s2 = '0; stb = '0; prs = '0;
        for (int b = 0; b < NB; b++) runlen[b] = 0;
    endtask

    task automatic compare_all();
        check("hex", HEX, m_hex);
        check("mode", mode, m_mode);
        check("buttons", buttons, stb);
        check("press", button_press, prs);
        check("heartbeat", heartbeat, m_hb);
        check("running", running, m_run);
    endtask

    // one clock: advance the model from pre-edge state and inputs, then compare after the edge
    task automatic cycle();
        logic [27:0] n_hex;
        int n_mode, t;
        bit n_hb;
        n_hex = disp();
        n_mode = LOCKUP ? 2 : prs[0] ? (m_mode == 0 ? 1 : 0) : m_mode;
        t = m_tick % 32;
        n_hb = (t >= 20 && t < 24) || t >= 28;
        for (int b = 0; b < NB; b++) begin
            prs[b] = 0;
            if (s2[b] != stb[b]) begin
                if (runlen[b] == 7) begin
                    prs[b] = !stb[b];
                    stb[b] = !stb[b];
                    runlen[b] = 0;
                end else runlen[b]++;
            end else runlen[b] = 0;
            s2[b] = s1[b];
            s1[b] = !KEY_n[b];
        end
        if (bus.value_valid) m_val = bus.value;
        m_hex = n_hex; m_mode = n_mode; m_hb = n_hb; m_run = 1; m_tick++;
        @(posedge CLOCK_50);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        HRESETn = 1'b0;
        model_reset();
        #1;
        check("rst_hex", HEX, 28'hFFFFFFF);
        check("rst_mode", mode, 0);
        check("rst_buttons", buttons, 0);
        check("rst_press", button_press, 0);
        check("rst_running", running, 0);
        check("rst_hb", heartbeat, 0);
        @(posedge CLOCK_50);
        #1;
        HRESETn = 1'b1;
    endtask

    task automatic wait_press(input string tag);
        int k;
        k = 0;
        while (button_press[0] !== 1'b1 && k < 20) begin
            cycle();
            k++;
        end
        check(tag, button_press[0], 1);
    endtask

    initial begin
        int cnt, on, off;
        bus.value = '0;
        bus.value_valid = 1'b0;
        #2;
        do_reset();
        for (int n = 1; n <= 40; n++) begin
            int t;
            cycle();
            t = (n - 1) % 32;
            check("hb_spec", heartbeat, ((t >= 20 && t < 24) || t >= 28) ? 1 : 0);
            if (n == 1) check("run_first", running, 1);
        end

        cnt = 0;
        KEY_n[0] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            bus.value = 16'hBEEF;
            bus.value_valid = (k == 3);
            cycle();
            cnt += button_press[0];
            if (k == 9) check("btn_lat_lo", buttons[0], 0);
            if (k == 10) check("btn_lat_hi", buttons[0], 1);
        end
        bus.value_valid = 1'b0;
        check("beef_mode", mode, 1);
        check("beef_hex", HEX, {7'h03, 7'h06, 7'h06, 7'h0E});
        KEY_n[0] = 1'b1;
        repeat (14) cycle();
        check("press_once", cnt, 1);
        check("release", buttons[0], 0);

        cnt = 0;
        KEY_n[0] = 1'b0;
        repeat (5) cycle();
        KEY_n[0] = 1'b1;
        for (int k = 0; k < 15; k++) begin
            cycle();
            cnt += buttons[0];
        end
        check("glitch", cnt, 0);

        KEY_n[0] = 1'b0;
        wait_press("press_wait_lock");
        LOCKUP = 1'b1;
        cycle();
        check("lock_prio", mode, 2);
        KEY_n[0] = 1'b1;
        on = 0; off = 0;
        repeat (40) begin
            cycle();
            if (HEX == {LG, OG, CG, PG}) on++;
            if (HEX == 28'hFFFFFFF) off++;
        end
        check("blink_on", on > 0, 1);
        check("blink_off", off > 0, 1);
        LOCKUP = 1'b0;
        repeat (15) cycle();
        check("lock_hold", mode, 2);
        KEY_n[0] = 1'b0;
        wait_press("press_wait_ack");
        cycle();
        cycle();
        check("ack_mode", mode, 0);
        check("ack_d3", HEX[27:21], BL);
        check("ack_d1", HEX[13:7], DG);
        KEY_n[0] = 1'b1;
        repeat (12) cycle();

        repeat (3000) begin
            for (int b = 0; b < NB; b++) if ($urandom_range(0, 15) == 0) KEY_n[b] = ~KEY_n[b];
            if ($urandom_range(0, 63) == 0) LOCKUP = ~LOCKUP;
            bus.value = 16'($urandom);
            bus.value_valid = ($urandom_range(0, 3) == 0);
            cycle();
        end

        LOCKUP = 1'b0;
        KEY_n = '1;
        bus.value_valid = 1'b0;
        repeat (15) cycle();
        for (int i = 0; i < 3 && m_mode != 1; i++) begin
            KEY_n[0] = 1'b0;
            repeat (12) cycle();
            KEY_n[0] = 1'b1;
            repeat (12) cycle();
        end
        check("pre_rst_mode", mode, 1);
        KEY_n[0] = 1'b0;
        repeat (5) cycle();
        #3;
        do_reset();
        repeat (20) cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
